rf_multiport: RTL and testbench

//   Parametrised multi-port register file for the pipelined datapath. It supports N read and
//   M write ports, optional same-cycle write-to-read bypass, and a pending-write scoreboard.

---
 rtl/rf_multiport_if.sv | 30 +++
 rtl/rf_multiport.sv | 107 ++++++++++
 tb/tb_rf_multiport.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_multiport_if.sv
// Register-file bus bundle: write ports, read ports, reservation and flush.
// The issuing side uses the master modport; the register file uses the slave modport.
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NWR-1:0]        wen;
    logic [NWR*AW-1:0]     wsel;
    logic [NWR*DATA_W-1:0] wdat;
    logic [NRD*AW-1:0]     rsel;
    logic [NRD*DATA_W-1:0] rdat;
    logic [NRD-1:0]        busy;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_sel;
    logic                  flush;

    modport master (
        output wen, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
        input  rdat, busy
    );

    modport slave (
        input  wen, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
        output rdat, busy
    );
endinterface

// File: rtl/rf_multiport.sv
// Multi-port register file with pending-write scoreboard.
// NWR write ports (highest port index wins on an address collision), NRD
// combinational read ports with optional same-cycle write forwarding, and one
// pending bit per register so decode can spot RAW hazards. With ZERO_REG set,
// register 0 has no storage: it reads 0 and can never be pending.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic           CLK,
    input  logic           nRST,
    rf_multiport_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Addresses are AW bits wide, so every address must map to a register.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rf_multiport: DEPTH must be a power of two >= 2");
    end

    // Flattened view of storage and pending bits for the read ports.
    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             pend_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign regs_q[gi] = '0;
            assign pend_q[gi] = 1'b0;
        end else begin : g_store
            logic              wr_hit;
            logic [DATA_W-1:0] wr_data;
            logic [DATA_W-1:0] data_reg;
            logic              pend_reg;

            // Pick the write aimed at this register; later (higher) ports overwrite earlier ones.
            always_comb begin
                wr_hit  = 1'b0;
                wr_data = '0;
                for (int k = 0; k < NWR; k++) begin
                    if (bus.wen[k] && (bus.wsel[k*AW +: AW] == AW'(gi))) begin
                        wr_hit  = 1'b1;
                        wr_data = bus.wdat[k*DATA_W +: DATA_W];
                    end
                end
            end

            // Register storage: one-cycle write latency.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    data_reg <= '0;
                end else if (wr_hit) begin
                    data_reg <= wr_data;
                end
            end

            // Pending bit: flush beats a new reservation, which beats a completing write.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    pend_reg <= 1'b0;
                end else if (bus.flush) begin
                    pend_reg <= 1'b0;
                end else if (bus.rsv_en && (bus.rsv_sel == AW'(gi))) begin
                    pend_reg <= 1'b1;
                end else if (wr_hit) begin
                    pend_reg <= 1'b0;
                end
            end

            assign regs_q[gi] = data_reg;
            assign pend_q[gi] = pend_reg;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              byp_hit;
        logic [DATA_W-1:0] byp_data;
        logic [DATA_W-1:0] rd_data;
        logic              rd_busy;

        assign addr = bus.rsel[gi*AW +: AW];

        // Read mux: forward the winning same-cycle write if enabled, else the stored
        // value; a forwarded read is not busy since its producer is completing now.
        always_comb begin
            byp_hit  = 1'b0;
            byp_data = '0;
            if ((BYPASS != 0) && ((ZERO_REG == 0) || (addr != '0))) begin
                for (int k = 0; k < NWR; k++) begin
                    if (bus.wen[k] && (bus.wsel[k*AW +: AW] == addr)) begin
                        byp_hit  = 1'b1;
                        byp_data = bus.wdat[k*DATA_W +: DATA_W];
                    end
                end
            end
            rd_data = byp_hit ? byp_data : regs_q[addr];
            rd_busy = pend_q[addr] && !byp_hit;
        end

        assign bus.rdat[gi*DATA_W +: DATA_W] = rd_data;
        assign bus.busy[gi]                  = rd_busy;
    end
endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a default instance (2R/2W, bypass, zero register) driven
// through scenario tasks, plus a 4R/1W 64-bit no-bypass instance checked against
// a reference model with random writes.
module tb_rf_multiport;
    logic CLK;
    logic nRST;

    rf_multiport_if #(.DATA_W(32), .DEPTH(32), .NRD(2), .NWR(2)) bus1 ();
    rf_multiport_if #(.DATA_W(64), .DEPTH(32), .NRD(4), .NWR(1)) bus2 ();

    rf_multiport #(.DATA_W(32), .DEPTH(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus1.slave)
    );

    rf_multiport #(.DATA_W(64), .DEPTH(32), .NRD(4), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut2 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus2.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          kind;   // 0: rdat, 1: busy
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] sb2_q[$];
    logic [63:0] m_regs [32];
    int checks = 0;
    int errors = 0;

    task automatic drive_idle();
        bus1.wen = '0; bus1.wsel = '0; bus1.wdat = '0;
        bus1.rsv_en = 1'b0; bus1.rsv_sel = '0; bus1.flush = 1'b0;
        bus1.rsel = '0;
    endtask

    task automatic set_wr(input int k, input int addr, input logic [31:0] d);
        bus1.wen[k] = 1'b1;
        bus1.wsel[k*5 +: 5] = 5'(addr);
        bus1.wdat[k*32 +: 32] = d;
    endtask

    task automatic set_rd(input int a0, input int a1);
        bus1.rsel = {5'(a1), 5'(a0)};
    endtask

    task automatic set_rsv(input int addr);
        bus1.rsv_en = 1'b1;
        bus1.rsv_sel = 5'(addr);
    endtask

    task automatic expect_val(input int kind, input int port, input logic [63:0] val);
        exp_t e;
        e.kind = kind; e.port = port; e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic [63:0] observe1(input int kind, input int port);
        if (kind == 0) return {32'h0, bus1.rdat[port*32 +: 32]};
        return {63'h0, bus1.busy[port]};
    endfunction

    task automatic test_reset();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 36; s++) begin
            drive_idle();
            if (s == 0) begin
                set_rd(5, 9);
                expect_val(0, 0, 0); expect_val(0, 1, 0); expect_val(1, 0, 0); expect_val(1, 1, 0);
            end else if (s <= 16) begin
                set_wr(0, 2*(s-1)+1, 32'hA500_0000 | 32'(2*(s-1)+1));
                if (2*(s-1)+2 < 32) set_wr(1, 2*(s-1)+2, 32'hA500_0000 | 32'(2*(s-1)+2));
            end else if (s == 17) begin
                set_rsv(10);
            end else if (s == 18) begin
                set_rd(31, 10);
                expect_val(0, 0, 64'hA500_001F); expect_val(0, 1, 64'hA500_000A);
                expect_val(1, 0, 0); expect_val(1, 1, 1);
            end else if (s == 19) begin
                set_rd(31, 10);
                expect_val(0, 0, 0); expect_val(0, 1, 0); expect_val(1, 1, 0);
            end else begin
                set_rd(2*(s-20)+1, (2*(s-20)+2) % 32);
                expect_val(0, 0, 0); expect_val(0, 1, 0); expect_val(1, 0, 0); expect_val(1, 1, 0);
            end
            if (s == 19) begin nRST = 1'b0; #1; end
            else @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe1(e.kind, e.port);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL reset_step%0d_%s%0d: got %h expected %h", s,
                             (e.kind == 0) ? "rdat" : "busy", e.port, got, e.val);
                end
            end
            if (s == 0 || s == 19) nRST = 1'b1;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_basic();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 2; s++) begin
            drive_idle();
            case (s)
                0: begin
                    set_wr(0, 5, 32'hDEAD_BEEF); set_wr(1, 0, 32'h0000_1234); set_rd(0, 0);
                    expect_val(0, 0, 0); expect_val(0, 1, 0);
                end
                default: begin
                    set_rd(5, 0);
                    expect_val(0, 0, 64'hDEAD_BEEF); expect_val(0, 1, 0);
                end
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe1(e.kind, e.port);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL basic_step%0d_%s%0d: got %h expected %h", s,
                             (e.kind == 0) ? "rdat" : "busy", e.port, got, e.val);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_collision();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 4; s++) begin
            drive_idle();
            case (s)
                0: begin
                    set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(7, 7);
                    expect_val(0, 0, 64'h22); expect_val(0, 1, 64'h22);
                end
                1: begin
                    set_rd(0, 7);
                    expect_val(0, 0, 0); expect_val(0, 1, 64'h22);
                end
                2: begin
                    set_wr(0, 8, 32'h33); set_wr(1, 9, 32'h44); set_rd(9, 8);
                    expect_val(0, 0, 64'h44); expect_val(0, 1, 64'h33);
                end
                default: begin
                    set_rd(8, 9);
                    expect_val(0, 0, 64'h33); expect_val(0, 1, 64'h44);
                end
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe1(e.kind, e.port);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL collision_step%0d_%s%0d: got %h expected %h", s,
                             (e.kind == 0) ? "rdat" : "busy", e.port, got, e.val);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 6; s++) begin
            drive_idle();
            case (s)
                0: begin set_rsv(9); set_rd(9, 9); expect_val(1, 0, 0); expect_val(1, 1, 0); end
                1: begin set_rd(9, 0); expect_val(1, 0, 1); expect_val(1, 1, 0); end
                2: begin
                    set_wr(1, 9, 32'h55); set_rd(9, 9);
                    expect_val(1, 0, 0); expect_val(0, 0, 64'h55); expect_val(1, 1, 0);
                end
                3: begin set_rd(9, 9); expect_val(1, 0, 0); expect_val(0, 1, 64'h55); end
                4: begin set_rsv(0); set_rd(0, 0); expect_val(1, 0, 0); end
                default: begin set_rd(0, 9); expect_val(1, 0, 0); expect_val(1, 1, 0); end
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe1(e.kind, e.port);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL scoreboard_step%0d_%s%0d: got %h expected %h", s,
                             (e.kind == 0) ? "rdat" : "busy", e.port, got, e.val);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_rsv_vs_write();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 5; s++) begin
            drive_idle();
            case (s)
                0: begin
                    set_rsv(3); set_wr(0, 3, 32'h77); set_rd(3, 3);
                    expect_val(1, 0, 0); expect_val(0, 0, 64'h77);
                end
                1: begin
                    set_rsv(12); set_rd(3, 12);
                    expect_val(1, 0, 1); expect_val(0, 0, 64'h77); expect_val(1, 1, 0);
                end
                2: begin
                    bus1.flush = 1'b1; set_rsv(4); set_rd(3, 12);
                    expect_val(1, 0, 1); expect_val(1, 1, 1);
                end
                3: begin set_rd(4, 3); expect_val(1, 0, 0); expect_val(1, 1, 0); end
                default: begin set_rd(12, 0); expect_val(1, 0, 0); end
            endcase
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe1(e.kind, e.port);
                checks++;
                if (got !== e.val) begin
                    errors++;
                    $display("FAIL rsv_write_step%0d_%s%0d: got %h expected %h", s,
                             (e.kind == 0) ? "rdat" : "busy", e.port, got, e.val);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_sweep();
        logic [63:0] exp;
        logic [63:0] got;
        int addr;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        for (int c = 0; c < 40; c++) begin
            bus2.wen   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            bus2.wsel  = 5'($urandom_range(0, 31));
            bus2.wdat  = {$urandom, $urandom};
            for (int p = 0; p < 4; p++) begin
                addr = (p == 0) ? int'(bus2.wsel) : int'($urandom_range(0, 31));
                bus2.rsel[p*5 +: 5] = 5'(addr);
                sb2_q.push_back(m_regs[addr]);
            end
            @(negedge CLK);
            for (int p = 0; p < 4; p++) begin
                exp = sb2_q.pop_front();
                got = bus2.rdat[p*64 +: 64];
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sweep_cyc%0d_rdat%0d: got %h expected %h", c, p, got, exp);
                end
            end
            checks++;
            if (bus2.busy !== 4'b0000) begin
                errors++;
                $display("FAIL sweep_cyc%0d_busy: got %b expected 0000", c, bus2.busy);
            end
            @(posedge CLK);
            if (bus2.wen && (bus2.wsel != 5'd0)) m_regs[bus2.wsel] = bus2.wdat;
            #1;
        end
        bus2.wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0;
        drive_idle();
        bus2.wen = '0; bus2.wsel = '0; bus2.wdat = '0; bus2.rsel = '0;
        bus2.rsv_en = 1'b0; bus2.rsv_sel = '0; bus2.flush = 1'b0;
        test_reset();
        test_basic();
        test_collision();
        test_scoreboard();
        test_rsv_vs_write();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
